// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizes the keyboard pins, assembles 11-bit frames,
// validates start/stop/odd parity and queues good scan bytes in a show-ahead FIFO.
module ps2_kbd #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       sig_rd_kb,
    output logic [7:0] kb_rdata,
    output logic       kb_ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic              clk_s1, clk_s2, clk_hist;
    logic              data_s1, data_s2;
    logic              fall;
    logic [10:0]       frame, frame_next;
    logic [3:0]        bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              last_bit, frame_ok, push, pop, full, wr_en;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        mem [FIFO_DEPTH];

    // Idle-high reset values keep a falling edge from being seen right after release.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall       = clk_hist & ~clk_s2;
    assign frame_next = {data_s2, frame[10:1]};
    assign last_bit   = fall && (bit_cnt == 4'd10);
    assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);
    assign push       = last_bit & frame_ok;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            frame     <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= last_bit & ~frame_ok;
            if (fall) begin
                frame    <= frame_next;
                idle_cnt <= '0;
                bit_cnt  <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is silently abandoned.
                if (idle_cnt == IDLE_W'(TIMEOUT)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

    assign kb_ready = (count != '0);
    assign pop      = sig_rd_kb & kb_ready;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign wr_en    = push & (~full | pop);
    assign kb_rdata = kb_ready ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !wr_en)
                count <= count - CNT_W'(1);
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= frame_next[8:1];
    end

endmodule
